// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared FSM state type and default widths for reg_bus_arbiter.
// Build option: REG_BUS_ARBITER_FIXED_PRIO_EN selects fixed-priority arbitration.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int unsigned DEF_N_REQ      = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 9;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot winner selection among N_REQ requesters.
// Default: round-robin, search starts just after the last accepted winner.
// With REG_BUS_ARBITER_FIXED_PRIO_EN defined: lowest index wins, no pointer.
module rr_arbiter
    import reg_bus_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

`ifdef REG_BUS_ARBITER_FIXED_PRIO_EN

    logic             found;
    logic [IDX_W-1:0] idx;

    // Lowest requesting index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IDX_W'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   pos;
    logic             found;

    // Scan from ptr+1 upwards with wrap; first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            idx = pos[IDX_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer remembers the last winner; reset value makes requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDX_W'(N_REQ - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

`endif

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register bus among N_REQ requesters.
// One transaction in flight: IDLE (accept) -> ISSUE (bus access) -> RESP.
// Build option: REG_BUS_ARBITER_FIXED_PRIO_EN (see rr_arbiter).
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int unsigned N_REQ      = DEF_N_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESET,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [N_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [N_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [ADDR_WIDTH-1:0]            mem_wrAddr,
    output logic [ADDR_WIDTH-1:0]            mem_rdAddr,
    output logic [DATA_WIDTH-1:0]            mem_wrdin,
    output logic [DATA_WIDTH/8-1:0]          mem_wrByteStrobe,
    output logic                             mem_rdStrobe,
    input  logic [DATA_WIDTH-1:0]            mem_rddout,
    output logic                             busy
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    state_t                  state;
    logic [N_REQ-1:0]        grant;
    logic                    accept;
    logic [N_REQ-1:0]        win_q;
    logic                    we_q;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [SW-1:0]           sel_wstrb;

    assign accept    = (state == IDLE) && (|req_valid);
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk    (S_AXI_ACLK),
        .rst    (S_AXI_ARESET),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // One-hot mux of the winning requester's fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = req_wstrb[i*SW +: SW];
            end
        end
    end

    // Transaction FSM; bus outputs are registered so they line up with ISSUE.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state            <= IDLE;
            win_q            <= '0;
            we_q             <= 1'b0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            mem_wrAddr       <= '0;
            mem_rdAddr       <= '0;
            mem_wrdin        <= '0;
            mem_wrByteStrobe <= '0;
            mem_rdStrobe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= '0;
                    if (accept) begin
                        win_q <= grant;
                        we_q  <= sel_we;
                        if (sel_we) begin
                            mem_wrAddr       <= sel_addr;
                            mem_wrdin        <= sel_wdata;
                            mem_wrByteStrobe <= sel_wstrb;
                        end else begin
                            mem_rdAddr   <= sel_addr;
                            mem_rdStrobe <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wrByteStrobe <= '0;
                    mem_rdStrobe     <= 1'b0;
                    rsp_valid        <= win_q;
                    rsp_rdata        <= we_q ? '0 : mem_rddout;
                    state            <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid        <= '0;
                    mem_wrByteStrobe <= '0;
                    mem_rdStrobe     <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, word-address width.
REQ-004 SHALL have port S_AXI_ACLK  in  1  the one clock; all logic on its rising edge.
REQ-005 SHALL have port S_AXI_ARESET  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester access request.
REQ-007 SHALL have port req_we  in  N_REQ  per-requester write (1) / read (0).
REQ-008 SHALL have port req_addr  in  N_REQ x ADDR_WIDTH  per-requester word address.
REQ-009 SHALL have port req_wdata  in  N_REQ x DATA_WIDTH  per-requester write data.
REQ-010 SHALL have port req_wstrb  in  N_REQ x DATA_WIDTH/8  per-requester byte strobes.
REQ-011 SHALL have port req_ready  out  N_REQ  one-hot accept pulse.
REQ-012 SHALL have port rsp_valid  out  N_REQ  one-hot completion pulse.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid.
REQ-014 SHALL have ports mem_wrAddr/mem_rdAddr  out  ADDR_WIDTH  register-bus addresses.
REQ-015 SHALL have ports mem_wrdin  out  DATA_WIDTH; mem_wrByteStrobe  out  DATA_WIDTH/8; mem_rdStrobe  out  1.
REQ-016 SHALL have port mem_rddout  in  DATA_WIDTH  combinational read data from register bus.
REQ-017 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-018 SHALL use FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction in flight.
REQ-019 IDLE: when any req_valid is high, SHALL select a winner, pulse its req_ready for that cycle, latch we/addr/wdata/wstrb/index, go to ISSUE.
REQ-020 Default arbitration SHALL be round-robin: search starts at index after last winner; pointer updates on every accept.
REQ-021 ISSUE (one cycle): write drives mem_wrAddr/mem_wrdin and mem_wrByteStrobe=latched wstrb; read drives mem_rdAddr and mem_rdStrobe=1; read captures mem_rddout at end of cycle.
REQ-022 Outside ISSUE, mem_wrByteStrobe SHALL be 0 and mem_rdStrobe 0; addresses/data hold last value.
REQ-023 RESP: rsp_valid[winner]=1 for exactly one cycle; rsp_rdata=captured data for reads, 0 for writes; then IDLE.
REQ-024 Latency accept-to-rsp_valid SHALL be 2 cycles; max throughput one transaction per 3 cycles.
REQ-025 Write with wstrb=0 SHALL complete normally with no byte written.
REQ-026 req_valid dropped after accept SHALL not affect the in-flight transaction; requests are not accepted in ISSUE/RESP.

Reset
REQ-027 On reset SHALL go to IDLE immediately; req_ready, rsp_valid, strobes, busy =0; addresses, mem_wrdin, rsp_rdata =0; RR pointer = N_REQ-1 (requester 0 first).
REQ-028 Reset mid-transaction SHALL abort without rsp_valid; no strobe asserted after reset assertion.

Configuration
REQ-029 Macro REG_BUS_ARBITER_FIXED_PRIO_EN: defined -> fixed priority, lowest index wins, RR pointer removed; undefined -> round-robin per REQ-020.

Structure
REQ-030 Package reg_bus_pkg SHALL hold FSM state typedef (IDLE, ISSUE, RESP) and default width constants.
REQ-031 Sub-module rr_arbiter (N_REQ-wide request/one-hot grant, pointer update) SHALL implement winner selection.

Verification
REQ-032 Single write req0 addr 3, wdata 0xDEADBEEF, wstrb 0xF -> ready0 cycle 0, mem_wrByteStrobe=0xF with mem_wrAddr=3 cycle 1, rsp_valid0 cycle 2.
REQ-033 Read req1 addr 5, mem_rddout=0x12345678 -> mem_rdStrobe cycle 1, rsp_valid1 with rsp_rdata=0x12345678 cycle 2.
REQ-034 Both requesters valid continuously, 6 transactions -> grants alternate 0,1,0,1,0,1 (fixed-prio build: all 0).
REQ-035 Write wstrb 0x0 -> mem_wrByteStrobe stays 0, rsp_valid still pulses.
REQ-036 Reset asserted in ISSUE -> strobes and busy drop immediately, no rsp_valid, next request granted to requester 0.
